// File: rtl/brick_field.sv
// brick_field: brick-wall manager for the breakout playfield.
//
// Holds a ROWS x COLS brick occupancy map, answers each ball position strobe
// with a hit/no-hit decision, clears struck bricks, and presents the lowest
// non-empty row (mask + index) back to the ball controller. Also keeps the
// score and the life count, and flags level-clear / game-over.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_new_game          one-cycle start/restart request (highest priority)
//   i_ball_valid        one-cycle strobe: i_ball_x / i_ball_y hold a new position
//   i_ball_x, i_ball_y  ball column / row (row grows upward)
//   i_fall_down         level, high while the ball is lost (rising edge = life lost)
//   o_brick_x           occupancy mask of row o_brick_y
//   o_brick_y           lowest non-empty row, ROWS when the field is empty
//   o_brick_valid       o_brick_x / o_brick_y are current (PLAY only)
//   o_hit               one-cycle pulse: a brick was cleared
//   o_score             bricks cleared this game, saturating at 255
//   o_lives             remaining lives
//   o_level_clear       field empty
//   o_game_over         lives exhausted
//   o_dbg_state         current FSM state encoding
//
// Interface semantics: there is no back-pressure on the brick interface. A
// ball position is consumed on every edge where i_ball_valid is high; it only
// has an effect in PLAY. o_brick_x / o_brick_y may be used only while
// o_brick_valid is high.
module brick_field #(
  parameter int COLS      = 10,
  parameter int ROWS      = 10,
  parameter int INIT_ROWS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_new_game,
  input  logic            i_ball_valid,
  input  logic [3:0]      i_ball_x,
  input  logic [3:0]      i_ball_y,
  input  logic            i_fall_down,
  output logic [COLS-1:0] o_brick_x,
  output logic [3:0]      o_brick_y,
  output logic            o_brick_valid,
  output logic            o_hit,
  output logic [7:0]      o_score,
  output logic [1:0]      o_lives,
  output logic            o_level_clear,
  output logic            o_game_over,
  output logic [2:0]      o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_SCAN    = 3'd3,
    S_CLEARED = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [3:0] ROWS_L    = 4'(ROWS);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [3:0] FIRST_ROW = 4'(ROWS - INIT_ROWS);
  localparam logic [4:0] COLS_L    = 5'(COLS);

  state_t            r_state, w_state_nxt;
  logic [COLS-1:0]   r_field [ROWS];
  logic [3:0]        r_ptr, w_ptr_nxt;
  logic [COLS-1:0]   r_brick_x, w_brick_x_nxt;
  logic [3:0]        r_brick_y, w_brick_y_nxt;
  logic              r_brick_valid, w_brick_valid_nxt;
  logic              r_hit, w_hit_nxt;
  logic [7:0]        r_score, w_score_nxt;
  logic [1:0]        r_lives, w_lives_nxt;
  logic              r_fall_q;

  logic              w_we;
  logic [3:0]        w_widx;
  logic [COLS-1:0]   w_wdata;
  logic [COLS-1:0]   w_col_sel;
  logic [COLS-1:0]   w_hit_mask;
  logic [COLS-1:0]   w_scan_row;
  logic              w_hit_cond;
  logic              w_fall_rise;

  // One-hot column select; a column beyond the field shifts out to zero.
  assign w_col_sel  = {{(COLS-1){1'b0}}, 1'b1} << i_ball_x;
  assign w_hit_mask = r_brick_x & ~w_col_sel;
  assign w_scan_row = (r_ptr < ROWS_L) ? r_field[r_ptr] : '0;
  // The ball strikes the brick row from directly below it.
  assign w_hit_cond = i_ball_valid && ({1'b0, i_ball_x} < COLS_L) &&
                      (({1'b0, i_ball_y} + 5'd1) == {1'b0, r_brick_y}) &&
                      (|(r_brick_x & w_col_sel));
  assign w_fall_rise = i_fall_down & ~r_fall_q;

  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_brick_x_nxt     = r_brick_x;
    w_brick_y_nxt     = r_brick_y;
    w_brick_valid_nxt = r_brick_valid;
    w_hit_nxt         = 1'b0;
    w_score_nxt       = r_score;
    w_lives_nxt       = r_lives;
    w_we              = 1'b0;
    w_widx            = r_ptr;
    w_wdata           = '0;

    if (i_new_game) begin
      w_state_nxt       = S_LOAD;
      w_ptr_nxt         = 4'd0;
      w_score_nxt       = 8'd0;
      w_lives_nxt       = 2'd3;
      w_brick_valid_nxt = 1'b0;
      w_brick_x_nxt     = '0;
      w_brick_y_nxt     = ROWS_L;
    end else begin
      case (r_state)
        S_LOAD: begin
          // Pointer runs 0..ROWS-1 writing rows, then one extra edge to enter play.
          if (r_ptr < ROWS_L) begin
            w_we      = 1'b1;
            w_widx    = r_ptr;
            w_wdata   = (r_ptr >= FIRST_ROW) ? '1 : '0;
            w_ptr_nxt = r_ptr + 4'd1;
          end else if (INIT_ROWS > 0) begin
            w_state_nxt       = S_PLAY;
            w_brick_y_nxt     = FIRST_ROW;
            w_brick_x_nxt     = '1;
            w_brick_valid_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_CLEARED;
            w_brick_y_nxt = ROWS_L;
            w_brick_x_nxt = '0;
          end
        end
        S_PLAY: begin
          if (w_hit_cond) begin
            w_we          = 1'b1;
            w_widx        = r_brick_y;
            w_wdata       = w_hit_mask;
            w_brick_x_nxt = w_hit_mask;
            w_hit_nxt     = 1'b1;
            w_score_nxt   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            if (w_hit_mask == '0) begin
              w_brick_valid_nxt = 1'b0;
              if (r_brick_y == LAST_ROW) begin
                w_state_nxt   = S_CLEARED;
                w_brick_y_nxt = ROWS_L;
                w_brick_x_nxt = '0;
              end else begin
                w_state_nxt = S_SCAN;
                w_ptr_nxt   = r_brick_y + 4'd1;
              end
            end
          end
        end
        S_SCAN: begin
          if (w_scan_row != '0) begin
            w_state_nxt       = S_PLAY;
            w_brick_y_nxt     = r_ptr;
            w_brick_x_nxt     = w_scan_row;
            w_brick_valid_nxt = 1'b1;
          end else if (r_ptr == LAST_ROW) begin
            w_state_nxt   = S_CLEARED;
            w_brick_y_nxt = ROWS_L;
            w_brick_x_nxt = '0;
          end else begin
            w_ptr_nxt = r_ptr + 4'd1;
          end
        end
        default: ;
      endcase

      // Losing the last life overrides whatever next state the case chose.
      if (w_fall_rise &&
          (r_state == S_PLAY || r_state == S_SCAN || r_state == S_CLEARED)) begin
        if (r_lives <= 2'd1) begin
          w_state_nxt       = S_OVER;
          w_lives_nxt       = 2'd0;
          w_brick_valid_nxt = 1'b0;
        end else begin
          w_lives_nxt = r_lives - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= 4'd0;
      r_brick_x     <= '0;
      r_brick_y     <= ROWS_L;
      r_brick_valid <= 1'b0;
      r_hit         <= 1'b0;
      r_score       <= 8'd0;
      r_lives       <= 2'd3;
      r_fall_q      <= 1'b0;
    end else begin
      r_ptr         <= w_ptr_nxt;
      r_brick_x     <= w_brick_x_nxt;
      r_brick_y     <= w_brick_y_nxt;
      r_brick_valid <= w_brick_valid_nxt;
      r_hit         <= w_hit_nxt;
      r_score       <= w_score_nxt;
      r_lives       <= w_lives_nxt;
      r_fall_q      <= i_fall_down;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) r_field[i] <= '0;
    end else if (w_we) begin
      r_field[w_widx] <= w_wdata;
    end
  end

  assign o_brick_x     = r_brick_x;
  assign o_brick_y     = r_brick_y;
  assign o_brick_valid = r_brick_valid;
  assign o_hit         = r_hit;
  assign o_score       = r_score;
  assign o_lives       = r_lives;
  assign o_level_clear = (r_state == S_CLEARED);
  assign o_game_over   = (r_state == S_OVER);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_brick_field.sv
// Testbench for brick_field: directed stimulus, a behavioural game model
// checked every cycle, plus hand-computed literal expectations.
module tb_brick_field;
  localparam int COLS      = 10;
  localparam int ROWS      = 10;
  localparam int INIT_ROWS = 3;

  // Model modes
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_SCAN = 3, M_CLR = 4, M_OVER = 5;

  logic            clk;
  logic            rst_n;
  logic            new_game, ball_valid, fall_down;
  logic [3:0]      ball_x, ball_y;
  logic [COLS-1:0] brick_x;
  logic [3:0]      brick_y;
  logic            brick_valid, hit, level_clear, game_over;
  logic [7:0]      score;
  logic [1:0]      lives;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  brick_field #(.COLS(COLS), .ROWS(ROWS), .INIT_ROWS(INIT_ROWS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_new_game   (new_game),
    .i_ball_valid (ball_valid),
    .i_ball_x     (ball_x),
    .i_ball_y     (ball_y),
    .i_fall_down  (fall_down),
    .o_brick_x    (brick_x),
    .o_brick_y    (brick_y),
    .o_brick_valid(brick_valid),
    .o_hit        (hit),
    .o_score      (score),
    .o_lives      (lives),
    .o_level_clear(level_clear),
    .o_game_over  (game_over),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_mode  = M_IDLE;
  int              m_cnt   = 0;
  int              m_wait  = 0;
  int              m_after = M_IDLE;
  int              m_score = 0;
  int              m_lives = 3;
  bit              m_hit   = 1'b0;
  bit              m_fall_q = 1'b0;
  logic [COLS-1:0] m_field [ROWS];
  int              mr, mt, m_pre, mbx;
  bit              m_rise;

  // Lowest-index row holding any brick; ROWS when the field is empty.
  function automatic int low_row();
    int res = ROWS;
    for (int r = ROWS - 1; r >= 0; r--) if (m_field[r] != '0) res = r;
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_wait = 0; m_score = 0; m_lives = 3;
      m_hit = 1'b0; m_fall_q = 1'b0;
      for (int r = 0; r < ROWS; r++) m_field[r] = '0;
    end else begin
      m_rise   = fall_down && !m_fall_q;
      m_fall_q = fall_down;
      m_hit    = 1'b0;
      m_pre    = m_mode;
      if (new_game) begin
        m_mode = M_LOAD; m_cnt = 0; m_score = 0; m_lives = 3;
      end else begin
        case (m_mode)
          M_LOAD: begin
            m_cnt++;
            if (m_cnt == ROWS + 1) begin
              for (int r = 0; r < ROWS; r++) m_field[r] = (r >= ROWS - INIT_ROWS) ? '1 : '0;
              m_mode = (INIT_ROWS > 0) ? M_PLAY : M_CLR;
            end
          end
          M_PLAY: begin
            mr  = low_row();
            mbx = int'(ball_x);
            if (ball_valid && mbx < COLS && mr < ROWS && int'(ball_y) + 1 == mr &&
                m_field[mr][mbx]) begin
              m_field[mr][mbx] = 1'b0;
              m_hit   = 1'b1;
              m_score = (m_score < 255) ? m_score + 1 : 255;
              if (m_field[mr] == '0) begin
                mt = low_row();
                if (mt == ROWS) begin
                  if (mr == ROWS - 1) m_mode = M_CLR;
                  else begin m_mode = M_SCAN; m_wait = ROWS - 1 - mr; m_after = M_CLR; end
                end else begin
                  m_mode = M_SCAN; m_wait = mt - mr; m_after = M_PLAY;
                end
              end
            end
          end
          M_SCAN: begin
            m_wait--;
            if (m_wait == 0) m_mode = m_after;
          end
          default: ;
        endcase
        if (m_rise && (m_pre == M_PLAY || m_pre == M_SCAN || m_pre == M_CLR)) begin
          if (m_lives <= 1) begin m_lives = 0; m_mode = M_OVER; end
          else m_lives--;
        end
      end
    end
  end

  // ---------------- scoreboard compare (every cycle out of reset) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("hit", hit, m_hit);
      check("score", score, m_score);
      check("lives", lives, m_lives);
      check("brick_valid", brick_valid, m_mode == M_PLAY);
      check("level_clear", level_clear, m_mode == M_CLR);
      check("game_over", game_over, m_mode == M_OVER);
      if (m_mode == M_PLAY) begin
        check("brick_y", brick_y, low_row());
        check("brick_x", brick_x, m_field[low_row()]);
      end else if (m_mode == M_CLR || m_mode == M_IDLE) begin
        check("brick_y_empty", brick_y, ROWS);
        check("brick_x_empty", brick_x, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input int x, input int y);
    @(negedge clk);
    ball_valid = 1'b1; ball_x = 4'(x); ball_y = 4'(y);
    @(negedge clk);
    ball_valid = 1'b0;
  endtask

  task automatic pulse_ng();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic pulse_fall();
    @(negedge clk); fall_down = 1'b1;
    @(negedge clk); fall_down = 1'b0;
  endtask

  // Counts edges after the new_game sampling edge until brick_valid rises.
  task automatic wait_valid(input string name);
    int edges = 0;
    while (brick_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check(name, edges, ROWS + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; new_game = 1'b0; ball_valid = 1'b0; fall_down = 1'b0;
    ball_x = 4'd0; ball_y = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_brick_x", brick_x, 0);
    check("rst_brick_y", brick_y, 10);
    check("rst_lives", lives, 3);
    check("rst_flags", {brick_valid, hit, level_clear, game_over}, 0);
    check("rst_score", score, 0);
    rst_n = 1'b1;

    // Idle ignores ball strobes
    strobe(4, 6);
    check("idle_hit", hit, 0);
    check("idle_valid", brick_valid, 0);

    // Load
    pulse_ng();
    wait_valid("load_latency");
    check("load_brick_y", brick_y, 7);
    check("load_brick_x", brick_x, 'h3FF);
    check("load_score", score, 0);

    // First hit, then repeat misses
    strobe(4, 6);
    check("hit1_pulse", hit, 1);
    check("hit1_brick_x", brick_x, 'h3EF);
    check("hit1_score", score, 1);
    strobe(4, 6);
    check("rehit_pulse", hit, 0);
    check("rehit_score", score, 1);
    strobe(12, 6);
    strobe(3, 5);
    strobe(3, 7);
    check("miss_score", score, 1);

    // Clear row 7, then scan to row 8
    for (int x = 0; x < COLS; x++) if (x != 4) strobe(x, 6);
    check("row7_scan_valid", brick_valid, 0);
    check("row7_score", score, 10);
    @(negedge clk);
    check("row8_valid", brick_valid, 1);
    check("row8_brick_y", brick_y, 8);
    check("row8_brick_x", brick_x, 'h3FF);

    // Clear rows 8 and 9
    for (int x = 0; x < COLS; x++) strobe(x, 7);
    @(negedge clk);
    for (int x = 0; x < COLS; x++) strobe(x, 8);
    check("clr_level_clear", level_clear, 1);
    check("clr_brick_y", brick_y, 10);
    check("clr_brick_x", brick_x, 0);
    check("clr_score", score, 30);

    // Lives run out
    pulse_fall(); check("lives_a", lives, 2);
    pulse_fall(); check("lives_b", lives, 1);
    pulse_fall(); check("lives_c", lives, 0);
    check("over_flag", game_over, 1);
    check("over_level_clear", level_clear, 0);
    pulse_fall(); check("lives_floor", lives, 0);

    // New game, restarted mid-load
    pulse_ng();
    check("ng_lives", lives, 3);
    check("ng_score", score, 0);
    check("ng_game_over", game_over, 0);
    repeat (4) @(negedge clk);
    pulse_ng();
    wait_valid("reload_latency");

    // Simultaneous hit and last life lost
    pulse_fall(); pulse_fall();
    check("lives_one", lives, 1);
    @(negedge clk);
    ball_valid = 1'b1; ball_x = 4'd0; ball_y = 4'd6; fall_down = 1'b1;
    @(negedge clk);
    ball_valid = 1'b0; fall_down = 1'b0;
    check("simul_hit", hit, 1);
    check("simul_score", score, 1);
    check("simul_over", game_over, 1);
    check("simul_valid", brick_valid, 0);

    // new_game aborts a scan
    pulse_ng();
    wait_valid("load3_latency");
    for (int x = 0; x < COLS; x++) strobe(x, 6);
    check("scan_valid", brick_valid, 0);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("abort_score", score, 0);
    check("abort_valid", brick_valid, 0);
    wait_valid("abort_reload_latency");
    check("abort_brick_y", brick_y, 7);
    check("abort_brick_x", brick_x, 'h3FF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brick_field.md
# brick_field

Brick-wall manager for the 10×10 breakout playfield: holds the brick occupancy map, and answers the ball controller's per-step position with a hit/no-hit decision. It clears struck bricks and presents the lowest non-empty brick row back as `brick_x`/`brick_y`. It sits opposite the ball controller on the brick interface. It also keeps score and lives, and flags level-clear and game-over for the display and top-level logic.

## Interface
- `COLS`, 10: playfield width; `brick_x` width; must be ≤16.
- `ROWS`, 10: playfield height; must be ≤15.
- `INIT_ROWS`, 3: number of top rows filled on load; must be ≤ROWS.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `new_game`  in  1  one-cycle start/restart request.
- `ball_valid`  in  1  one-cycle strobe: `ball_x`/`ball_y` hold a new ball position.
- `ball_x`  in  4  ball column.
- `ball_y`  in  4  ball row (y increases upward).
- `fall_down`  in  1  level from ball controller; high while ball is lost.
- `brick_x`  out  COLS  occupancy mask of row `brick_y`; bit i = column i.
- `brick_y`  out  4  index of lowest non-empty row; ROWS when field empty.
- `brick_valid`  out  1  `brick_x`/`brick_y` are current (PLAY only).
- `hit`  out  1  one-cycle pulse: a brick was cleared.
- `score`  out  8  bricks cleared this game, saturating at 255.
- `lives`  out  2  remaining lives.
- `level_clear`  out  1  field empty (CLEARED state).
- `game_over`  out  1  lives exhausted (OVER state).

## Operation
- Storage: ROWS registers of COLS bits each; row pointer 4 bits.
- Reset:
  - state IDLE, field all zero.
  - Outputs: `brick_x`=0, `brick_y`=ROWS, `brick_valid`=0, `hit`=0, `score`=0, `lives`=3, `level_clear`=0, `game_over`=0.
- States: IDLE, LOAD, PLAY, SCAN, CLEARED, OVER.
- `new_game` is sampled in every state and has priority over all other events:
  - → LOAD, row pointer=0, `score`=0, `lives`=3.
  - `brick_valid`, `level_clear`, `game_over` all 0.
- LOAD:
  - One row written per cycle: row r = all-ones if r ≥ ROWS−INIT_ROWS, else 0.
  - After row ROWS−1 is written:
    - INIT_ROWS>0 → PLAY, `brick_y`=ROWS−INIT_ROWS, `brick_x`=all-ones, `brick_valid`=1.
    - INIT_ROWS=0 → CLEARED.
- PLAY, hit condition: `ball_valid` & `ball_x`<COLS & `ball_y`+1==`brick_y` & `brick_x[ball_x]`. On a hit:
  - Clear the bit in the field row and in `brick_x`.
  - `hit`=1 for one cycle; `score`+1 (saturating).
  - If the resulting mask is zero → SCAN, `brick_valid`=0, pointer=`brick_y`+1.
  - If `brick_y`==ROWS−1 and the mask becomes zero → directly to CLEARED.
- PLAY, non-hit strobes: no effect.
- SCAN:
  - Each cycle, examine row[pointer].
  - Non-zero → PLAY with `brick_y`=pointer, `brick_x`=row, `brick_valid`=1.
  - Zero and pointer==ROWS−1 → CLEARED.
  - Otherwise pointer+1.
  - `ball_valid` ignored (no hit, no score).
- CLEARED:
  - `level_clear`=1, `brick_y`=ROWS, `brick_x`=0.
  - Held until `new_game`.
- Lives:
  - Rising edge of `fall_down` (registered previous value) in PLAY/SCAN/CLEARED → `lives`−1.
  - If `lives` was 1 → OVER: `game_over`=1, `brick_valid`=0, `lives`=0; held until `new_game`.
  - `fall_down` edges in IDLE/LOAD/OVER ignored; `lives` never wraps below 0.
- Simultaneous hit and `fall_down` rise in PLAY:
  - Hit is applied (bit cleared, score+1).
  - Life is lost.
  - OVER takes precedence over SCAN/CLEARED for next state.

## Timing
- All outputs registered; `hit`, `score`, `brick_x`, `brick_y` update on the same edge that samples the hit.
- Load latency: `brick_valid` rises ROWS+1 edges after the edge sampling `new_game` (11 with defaults).
- Scan latency: k edges, where k = rows between the cleared row and the next non-empty row (inclusive of the latter).
- `hit` is never high for two consecutive cycles unless `ball_valid` is.
- `new_game` mid-LOAD restarts LOAD at row 0; mid-SCAN aborts the scan.

## Test plan
- Reset, then release → `brick_x`=0, `brick_y`=10, `lives`=3, all flags 0; stays IDLE with ball strobes applied.
- `new_game` pulse → `brick_valid`=1 exactly 11 edges later, `brick_y`=7, `brick_x`=0x3FF, `score`=0.
- PLAY, strobe `ball_x`=4, `ball_y`=6 → `hit` one cycle, `brick_x`=0x3EF, `score`=1; repeat same strobe → no hit, score stays 1.
- Clear all 10 bricks of row 7 → `brick_valid` low one cycle, then `brick_y`=8, `brick_x`=0x3FF; clear rows 8 and 9 → `level_clear`=1, `brick_y`=10, `score`=30.
- Three `fall_down` pulses → `lives` 2,1,0, `game_over`=1 on third; fourth pulse → `lives` stays 0; `new_game` → `lives`=3, reload.
- Hit strobe and `fall_down` rise on same edge with `lives`=1 → `score`+1, `game_over`=1, `brick_valid`=0; `new_game` during SCAN → LOAD, `score`=0.
